// File: rtl/dff_share_arb.sv
// Shared WIDTH-bit storage register arbitrated between two writers.
// Round-robin on contention, optional settle gap after each load.
module dff_share_arb #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             C,
  input  logic             nR,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] wd0,
  input  logic [WIDTH-1:0] wd1,
  output logic [1:0]       gnt,
  output logic [1:0]       ack,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nQ,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SETL = 2'd2;

  // Last count value of the settle gap; unused when SETTLE is 0.
  localparam logic [3:0] LAST =
    (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  logic [1:0]       state;
  logic             sel;
  logic             ptr;
  logic [3:0]       cnt;
  logic             pick;
  logic             hit;
  logic [WIDTH-1:0] wd_sel;

  // Requester chosen for a new grant; pointer breaks ties.
  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      (req == 2'b11): pick = ptr;
      (req == 2'b10): pick = 1'b1;
      default:        pick = 1'b0;
    endcase
  end

  // Granted requester's data and its request still being held.
  always_comb begin
    wd_sel = sel ? wd1 : wd0;
    hit    = req[sel];
  end

  // Arbitration state, shared register and handshake outputs.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state <= IDLE;
      sel   <= 1'b0;
      ptr   <= 1'b0;
      cnt   <= 4'd0;
      gnt   <= 2'b00;
      ack   <= 2'b00;
      Q     <= '0;
    end else begin
      ack <= 2'b00;
      case (state)
        IDLE: begin
          if (|req) begin
            state <= LOAD;
            sel   <= pick;
            gnt   <= pick ? 2'b10 : 2'b01;
          end
        end
        LOAD: begin
          gnt <= 2'b00;
          if (hit) begin
            Q   <= wd_sel;
            ack <= sel ? 2'b10 : 2'b01;
            ptr <= ~sel;
            if (SETTLE > 0) begin
              state <= SETL;
              cnt   <= 4'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            state <= IDLE;
          end
        end
        SETL: begin
          if (cnt == LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

  // Complement and status follow the registers combinationally.
  always_comb begin
    nQ   = ~Q;
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_dff_share_arb.sv
// Bench for dff_share_arb: vector table, corner sequences and
// random traffic against a cycle-count reference model.
module tb_dff_share_arb;

  logic       C;
  logic       nR;
  logic [1:0] req;
  logic [7:0] wd0;
  logic [7:0] wd1;

  logic [1:0] gnt1, ack1, gnt0, ack0;
  logic [7:0] q1, nq1, q0, nq0;
  logic       busy1, busy0;

  int total = 0;
  int bad   = 0;

  dff_share_arb #(.WIDTH(8), .SETTLE(1)) dut1 (
    .C(C), .nR(nR), .req(req), .wd0(wd0), .wd1(wd1),
    .gnt(gnt1), .ack(ack1), .Q(q1), .nQ(nq1), .busy(busy1)
  );

  dff_share_arb #(.WIDTH(8), .SETTLE(0)) dut0 (
    .C(C), .nR(nR), .req(req), .wd0(wd0), .wd1(wd1),
    .gnt(gnt0), .ack(ack0), .Q(q0), .nQ(nq0), .busy(busy0)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  typedef struct {
    logic       in_load;
    logic       msel;
    int         free;
    logic       ptr;
    logic [7:0] q;
    logic [1:0] gnt;
    logic [1:0] ack;
  } mdl_t;

  mdl_t m1, m0;

  typedef struct {
    bit         rst;
    logic [1:0] r;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] g;
    logic [1:0] k;
    logic [7:0] q;
    logic       bz;
  } vec_t;

  vec_t tv[$];

  function automatic mdl_t mreset();
    mdl_t m;
    m.in_load = 1'b0;
    m.msel    = 1'b0;
    m.free    = 0;
    m.ptr     = 1'b0;
    m.q       = 8'h00;
    m.gnt     = 2'b00;
    m.ack     = 2'b00;
    return m;
  endfunction

  // One rising edge: a grant occupies one cycle, a completed load
  // then blocks new grants for s further cycles.
  function automatic mdl_t step(mdl_t m, int s, logic [1:0] r,
                                logic [7:0] a, logic [7:0] b);
    mdl_t n = m;
    n.gnt = 2'b00;
    n.ack = 2'b00;
    if (m.in_load) begin
      n.in_load = 1'b0;
      if (r[m.msel]) begin
        n.q    = m.msel ? b : a;
        n.ack  = 2'b01 << m.msel;
        n.ptr  = ~m.msel;
        n.free = s;
      end
    end else if (m.free > 0) begin
      n.free = m.free - 1;
    end else if (r != 2'b00) begin
      n.msel    = (r == 2'b11) ? m.ptr : r[1];
      n.in_load = 1'b1;
      n.gnt     = 2'b01 << n.msel;
    end
    return n;
  endfunction

  function automatic logic [20:0] pk(logic [1:0] g, logic [1:0] k,
                                     logic b, logic [7:0] q,
                                     logic [7:0] nq);
    return {g, k, b, q, nq};
  endfunction

  function automatic logic [20:0] mpk(mdl_t m);
    return pk(m.gnt, m.ack, m.in_load || (m.free > 0), m.q, ~m.q);
  endfunction

  task automatic chk(string nm, logic [20:0] got, logic [20:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Advance one edge, update models, compare both DUTs at negedge.
  task automatic cyc();
    @(posedge C);
    m1 = step(m1, 1, req, wd0, wd1);
    m0 = step(m0, 0, req, wd0, wd1);
    @(negedge C);
    chk("model_s1", pk(gnt1, ack1, busy1, q1, nq1), mpk(m1));
    chk("model_s0", pk(gnt0, ack0, busy0, q0, nq0), mpk(m0));
  endtask

  // Called at a negedge: reset asserted mid-low-phase, checked
  // before any edge, released at the following negedge.
  task automatic do_reset();
    #2;
    nR = 1'b0;
    #1;
    chk("rst_s1", pk(gnt1, ack1, busy1, q1, nq1),
        pk(2'b00, 2'b00, 1'b0, 8'h00, 8'hFF));
    chk("rst_s0", pk(gnt0, ack0, busy0, q0, nq0),
        pk(2'b00, 2'b00, 1'b0, 8'h00, 8'hFF));
    m1 = mreset();
    m0 = mreset();
    @(negedge C);
    nR = 1'b1;
  endtask

  function automatic vec_t mk(bit rs, logic [1:0] r, logic [7:0] a,
                              logic [7:0] b, logic [1:0] g,
                              logic [1:0] k, logic [7:0] q, logic bz);
    vec_t v;
    v.rst = rs; v.r = r; v.a = a; v.b = b;
    v.g = g; v.k = k; v.q = q; v.bz = bz;
    return v;
  endfunction

  initial begin
    nR  = 1'b0;
    req = 2'b00;
    wd0 = 8'h00;
    wd1 = 8'h00;
    m1  = mreset();
    m0  = mreset();

    // SETTLE=1 expectations, one record per rising edge.
    tv.push_back(mk(1, 2'b01, 8'hA5, 8'h00, 2'b01, 2'b00, 8'h00, 1));
    tv.push_back(mk(0, 2'b01, 8'hA5, 8'h00, 2'b00, 2'b01, 8'hA5, 1));
    tv.push_back(mk(0, 2'b00, 8'hA5, 8'h00, 2'b00, 2'b00, 8'hA5, 0));
    tv.push_back(mk(1, 2'b11, 8'h11, 8'h22, 2'b01, 2'b00, 8'h00, 1));
    tv.push_back(mk(0, 2'b11, 8'h11, 8'h22, 2'b00, 2'b01, 8'h11, 1));
    tv.push_back(mk(0, 2'b11, 8'h11, 8'h22, 2'b00, 2'b00, 8'h11, 0));
    tv.push_back(mk(0, 2'b11, 8'h11, 8'h22, 2'b10, 2'b00, 8'h11, 1));
    tv.push_back(mk(0, 2'b11, 8'h11, 8'h22, 2'b00, 2'b10, 8'h22, 1));
    tv.push_back(mk(0, 2'b11, 8'h11, 8'h22, 2'b00, 2'b00, 8'h22, 0));
    tv.push_back(mk(0, 2'b11, 8'h11, 8'h22, 2'b01, 2'b00, 8'h22, 1));
    tv.push_back(mk(0, 2'b11, 8'h11, 8'h22, 2'b00, 2'b01, 8'h11, 1));
    tv.push_back(mk(0, 2'b00, 8'h11, 8'h22, 2'b00, 2'b00, 8'h11, 0));
    tv.push_back(mk(0, 2'b10, 8'h11, 8'h77, 2'b10, 2'b00, 8'h11, 1));
    tv.push_back(mk(0, 2'b00, 8'h11, 8'h77, 2'b00, 2'b00, 8'h11, 0));
    tv.push_back(mk(0, 2'b11, 8'h11, 8'h22, 2'b10, 2'b00, 8'h11, 1));
    tv.push_back(mk(0, 2'b11, 8'h11, 8'h22, 2'b00, 2'b10, 8'h22, 1));
    tv.push_back(mk(0, 2'b00, 8'h11, 8'h22, 2'b00, 2'b00, 8'h22, 0));
    tv.push_back(mk(1, 2'b10, 8'h11, 8'h22, 2'b10, 2'b00, 8'h00, 1));
    tv.push_back(mk(0, 2'b00, 8'h11, 8'h22, 2'b00, 2'b00, 8'h00, 0));
    tv.push_back(mk(0, 2'b11, 8'h11, 8'h22, 2'b01, 2'b00, 8'h00, 1));
    tv.push_back(mk(0, 2'b11, 8'h11, 8'h22, 2'b00, 2'b01, 8'h11, 1));

    do_reset();
    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) begin
        req = 2'b00;
        do_reset();
      end
      req = tv[i].r;
      wd0 = tv[i].a;
      wd1 = tv[i].b;
      cyc();
      chk($sformatf("vec%0d", i), pk(gnt1, ack1, busy1, q1, nq1),
          pk(tv[i].g, tv[i].k, tv[i].bz, tv[i].q, ~tv[i].q));
    end

    // Back-to-back grants with no settle gap.
    req = 2'b00;
    do_reset();
    req = 2'b01;
    wd0 = 8'h5C;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("s0_stream%0d", i), {28'd0, gnt0, ack0},
          {28'd0, (i % 2 == 0) ? 2'b01 : 2'b00,
                  (i % 2 == 1) ? 2'b01 : 2'b00});
    end

    // Reset landing in the middle of a load.
    req = 2'b00;
    do_reset();
    req = 2'b01;
    wd0 = 8'h3C;
    cyc();
    chk("midrst_gnt", {19'd0, gnt1}, {19'd0, 2'b01});
    do_reset();
    cyc();
    chk("midrst_regnt", {19'd0, gnt1}, {19'd0, 2'b01});
    cyc();
    chk("midrst_load", {11'd0, ack1, q1}, {11'd0, 2'b01, 8'h3C});
    req = 2'b00;
    cyc();

    // Random traffic against the models.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      req = 2'($urandom_range(0, 3));
      wd0 = 8'($urandom);
      wd1 = 8'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
